// File: rtl/write_back_if.sv
// write_back_if: retiring-instruction inputs, register-file write port and UART handshakes of the write-back stage
interface write_back_if #(parameter int INST_MEM_WIDTH = 2);
  logic                      in_valid;
  logic                      stall;
  logic                      distinct;
  logic                      RegWrite;
  logic [1:0]                MemtoReg;
  logic                      UARTtoReg;
  logic                      RegtoUART;
  logic [4:0]                rw;
  logic [31:0]               alu_result;
  logic [31:0]               mem_data;
  logic [31:0]               tx_src;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic                      reg_we;
  logic                      reg_distinct;
  logic [4:0]                reg_waddr;
  logic [31:0]               reg_wdata;
  logic                      uart_rx_valid;
  logic [7:0]                uart_rx_data;
  logic                      uart_rx_ready;
  logic                      uart_tx_valid;
  logic [7:0]                uart_tx_data;
  logic                      uart_tx_ready;
  modport master (
    output in_valid, distinct, RegWrite, MemtoReg, UARTtoReg, RegtoUART, rw,
           alu_result, mem_data, tx_src, pc1, uart_rx_valid, uart_rx_data, uart_tx_ready,
    input  stall, reg_we, reg_distinct, reg_waddr, reg_wdata, uart_rx_ready,
           uart_tx_valid, uart_tx_data
  );
  modport slave (
    input  in_valid, distinct, RegWrite, MemtoReg, UARTtoReg, RegtoUART, rw,
           alu_result, mem_data, tx_src, pc1, uart_rx_valid, uart_rx_data, uart_tx_ready,
    output stall, reg_we, reg_distinct, reg_waddr, reg_wdata, uart_rx_ready,
           uart_tx_valid, uart_tx_data
  );
endinterface

// File: rtl/write_back.sv
// write_back: selects the retiring result, drives the register-file write port and runs blocking UART rx/tx
module write_back (
  input logic         CLK,
  input logic         reset,
  write_back_if.slave wb
);
  typedef enum logic [1:0] {IDLE, RX_WAIT, TX_WAIT} state_t;
  state_t      state, state_n;
  logic        acc, wr_rx, wr_norm, wr_en, wr_dist;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rx_distinct;
  logic [4:0]  rx_rw;
  logic        unused_bits;
  assign unused_bits      = ^wb.tx_src[31:8];
  assign wb.stall         = state != IDLE;
  assign wb.uart_rx_ready = state == RX_WAIT;
  assign wb.uart_tx_valid = state == TX_WAIT;
  assign acc              = wb.in_valid & ~wb.stall;
  always_comb begin
    state_n = state == IDLE    ? (acc & wb.UARTtoReg ? RX_WAIT : acc & wb.RegtoUART ? TX_WAIT : IDLE) :
              state == RX_WAIT ? (wb.uart_rx_valid ? IDLE : RX_WAIT) :
              state == TX_WAIT ? (wb.uart_tx_ready ? IDLE : TX_WAIT) : IDLE;
    wr_rx   = state == RX_WAIT & wb.uart_rx_valid;
    wr_norm = acc & ~wb.UARTtoReg & ~wb.RegtoUART & wb.RegWrite;
    wr_dist = wr_rx ? rx_distinct : wb.distinct;
    wr_addr = wr_rx ? rx_rw : wb.rw;
    wr_data = wr_rx                 ? {24'b0, wb.uart_rx_data} :
              wb.MemtoReg == 2'b01  ? wb.mem_data :
              wb.MemtoReg == 2'b10  ? 32'(wb.pc1) : wb.alu_result;
    // integer r0 is hardwired to zero, FP f0 is a real register
    wr_en   = (wr_rx | wr_norm) & (wr_dist | (|wr_addr));
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      wb.reg_we       <= 1'b0;
      wb.reg_distinct <= 1'b0;
      wb.reg_waddr    <= 5'd0;
      wb.reg_wdata    <= 32'd0;
      wb.uart_tx_data <= 8'd0;
      rx_distinct     <= 1'b0;
      rx_rw           <= 5'd0;
    end else begin
      state     <= state_n;
      wb.reg_we <= wr_en;
      if (wr_en) begin
        wb.reg_distinct <= wr_dist;
        wb.reg_waddr    <= wr_addr;
        wb.reg_wdata    <= wr_data;
      end
      if (acc & wb.UARTtoReg) begin
        rx_distinct <= wb.distinct;
        rx_rw       <= wb.rw;
      end
      if (acc & wb.RegtoUART & ~wb.UARTtoReg) wb.uart_tx_data <= wb.tx_src[7:0];
    end
  end
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed vectors with literal checks plus a per-cycle behavioural model of the write-back stage
module tb_write_back;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  write_back_if #(.INST_MEM_WIDTH(2)) wb();
  write_back dut (.CLK(CLK), .reset(reset), .wb(wb));
  always #5 CLK = ~CLK;
  int n_cmp = 0;
  int n_bad = 0;
  int w3_count = 0;
  int          m_pend = 0;
  logic        m_we = 0, m_dist = 0, m_rx_dist = 0;
  logic [4:0]  m_addr = 0, m_rx_addr = 0;
  logic [31:0] m_data = 0;
  logic [7:0]  m_txd = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] pc);
    case (sel)
      2'b01:   return mem;
      2'b10:   return {30'b0, pc};
      default: return alu;
    endcase
  endfunction
  // model: pending UART op (0 none, 1 rx, 2 tx) and the register-file write it implies
  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_pend <= 0; m_we <= 0; m_dist <= 0; m_addr <= 0; m_data <= 0; m_txd <= 0;
      m_rx_dist <= 0; m_rx_addr <= 0;
    end else begin
      m_we <= 0;
      if (m_pend == 1) begin
        if (wb.uart_rx_valid) begin
          m_pend <= 0;
          if (m_rx_dist || m_rx_addr != 0) begin
            m_we <= 1; m_dist <= m_rx_dist; m_addr <= m_rx_addr; m_data <= {24'b0, wb.uart_rx_data};
          end
        end
      end else if (m_pend == 2) begin
        if (wb.uart_tx_ready) m_pend <= 0;
      end else if (wb.in_valid) begin
        if (wb.UARTtoReg) begin
          m_pend <= 1; m_rx_dist <= wb.distinct; m_rx_addr <= wb.rw;
        end else if (wb.RegtoUART) begin
          m_pend <= 2; m_txd <= wb.tx_src[7:0];
        end else if (wb.RegWrite && (wb.distinct || wb.rw != 0)) begin
          m_we <= 1; m_dist <= wb.distinct; m_addr <= wb.rw;
          m_data <= pick(wb.MemtoReg, wb.alu_result, wb.mem_data, wb.pc1);
        end
      end
    end
  end
  always @(negedge CLK) begin
    if (!reset) begin
      chk("stall", wb.stall, m_pend != 0);
      chk("rx_ready", wb.uart_rx_ready, m_pend == 1);
      chk("tx_valid", wb.uart_tx_valid, m_pend == 2);
      chk("tx_data", wb.uart_tx_data, m_txd);
      chk("reg_we", wb.reg_we, m_we);
      chk("reg_distinct", wb.reg_distinct, m_dist);
      chk("reg_waddr", wb.reg_waddr, m_addr);
      chk("reg_wdata", wb.reg_wdata, m_data);
      if (wb.reg_we && wb.reg_waddr == 5'd3) w3_count++;
    end
  end
  task automatic clr();
    wb.in_valid = 0; wb.distinct = 0; wb.RegWrite = 0; wb.MemtoReg = 0; wb.UARTtoReg = 0;
    wb.RegtoUART = 0; wb.rw = 0; wb.alu_result = 0; wb.mem_data = 0; wb.tx_src = 0; wb.pc1 = 0;
    wb.uart_rx_valid = 0; wb.uart_rx_data = 0; wb.uart_tx_ready = 0;
  endtask
  task automatic norm(input logic d, input logic we, input logic [1:0] m, input logic [4:0] r,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] p);
    clr();
    wb.in_valid = 1; wb.distinct = d; wb.RegWrite = we; wb.MemtoReg = m; wb.rw = r;
    wb.alu_result = alu; wb.mem_data = mem; wb.pc1 = p;
  endtask
  initial begin
    clr();
    repeat (2) @(negedge CLK);
    chk("rst stall", wb.stall, 0);
    chk("rst reg_we", wb.reg_we, 0);
    chk("rst wdata", wb.reg_wdata, 0);
    chk("rst tx_data", wb.uart_tx_data, 0);
    reset = 0;
    norm(0, 1, 2'b00, 5, 32'h12345678, 0, 0);
    @(negedge CLK);
    chk("alu we", wb.reg_we, 1); chk("alu waddr", wb.reg_waddr, 5);
    chk("alu wdata", wb.reg_wdata, 32'h12345678); chk("alu stall", wb.stall, 0);
    norm(0, 1, 2'b01, 6, 0, 32'hDEADBEEF, 0);
    @(negedge CLK);
    chk("mem wdata", wb.reg_wdata, 32'hDEADBEEF); chk("mem we", wb.reg_we, 1);
    norm(0, 1, 2'b10, 7, 0, 0, 2'b11);
    @(negedge CLK);
    chk("link wdata", wb.reg_wdata, 32'h3);
    norm(0, 1, 2'b00, 0, 32'hAAAA, 0, 0);
    @(negedge CLK);
    chk("r0 we", wb.reg_we, 0); chk("r0 hold", wb.reg_wdata, 32'h3);
    norm(1, 1, 2'b00, 0, 32'h55, 0, 0);
    @(negedge CLK);
    chk("f0 we", wb.reg_we, 1); chk("f0 dist", wb.reg_distinct, 1); chk("f0 wdata", wb.reg_wdata, 32'h55);
    norm(0, 0, 2'b00, 8, 32'h99, 0, 0);
    @(negedge CLK);
    chk("nowr we", wb.reg_we, 0);
    clr(); wb.in_valid = 1; wb.UARTtoReg = 1; wb.rw = 9;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("rx stall", wb.stall, 1); chk("rx ready", wb.uart_rx_ready, 1); chk("rx we", wb.reg_we, 0);
      if (i == 0) norm(0, 1, 2'b00, 3, 32'h7, 0, 0);
      if (i == 4) begin wb.uart_rx_valid = 1; wb.uart_rx_data = 8'h41; end
    end
    @(negedge CLK);
    chk("rx wr we", wb.reg_we, 1); chk("rx wr addr", wb.reg_waddr, 9);
    chk("rx wr data", wb.reg_wdata, 32'h41); chk("rx done stall", wb.stall, 0);
    wb.uart_rx_valid = 0;
    @(negedge CLK);
    chk("held we", wb.reg_we, 1); chk("held addr", wb.reg_waddr, 3); chk("held data", wb.reg_wdata, 7);
    clr();
    @(negedge CLK);
    chk("held once", w3_count, 1);
    clr(); wb.in_valid = 1; wb.RegtoUART = 1; wb.RegWrite = 1; wb.rw = 4; wb.tx_src = 32'hCAFE00AB;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("tx valid", wb.uart_tx_valid, 1); chk("tx data", wb.uart_tx_data, 8'hAB);
      chk("tx stall", wb.stall, 1); chk("tx we", wb.reg_we, 0);
      if (i == 0) clr();
      if (i == 3) wb.uart_tx_ready = 1;
    end
    @(negedge CLK);
    chk("tx done valid", wb.uart_tx_valid, 0); chk("tx done stall", wb.stall, 0); chk("tx done we", wb.reg_we, 0);
    clr(); wb.in_valid = 1; wb.UARTtoReg = 1; wb.rw = 10; wb.uart_rx_valid = 1; wb.uart_rx_data = 8'h5A;
    @(negedge CLK);
    chk("zw stall", wb.stall, 1);
    wb.in_valid = 0;
    @(negedge CLK);
    chk("zw we", wb.reg_we, 1); chk("zw data", wb.reg_wdata, 32'h5A); chk("zw stall off", wb.stall, 0);
    clr(); wb.in_valid = 1; wb.UARTtoReg = 1; wb.RegtoUART = 1; wb.rw = 11; wb.tx_src = 32'h77;
    @(negedge CLK);
    chk("both rx", wb.uart_rx_ready, 1); chk("both tx", wb.uart_tx_valid, 0);
    clr(); wb.uart_rx_valid = 1; wb.uart_rx_data = 8'h33;
    @(negedge CLK);
    chk("both addr", wb.reg_waddr, 11); chk("both data", wb.reg_wdata, 32'h33); chk("both txd", wb.uart_tx_data, 8'hAB);
    clr(); wb.in_valid = 1; wb.UARTtoReg = 1; wb.rw = 12;
    @(negedge CLK);
    chk("mid stall", wb.stall, 1);
    clr();
    #2 reset = 1;
    #1;
    chk("async stall", wb.stall, 0); chk("async ready", wb.uart_rx_ready, 0);
    chk("async we", wb.reg_we, 0); chk("async wdata", wb.reg_wdata, 0); chk("async txd", wb.uart_tx_data, 0);
    wb.uart_rx_valid = 1; wb.uart_rx_data = 8'h99;
    @(negedge CLK);
    reset = 0;
    @(negedge CLK);
    chk("post rst we", wb.reg_we, 0); chk("post rst stall", wb.stall, 0); chk("post rst ready", wb.uart_rx_ready, 0);
    clr();
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
